// File: rtl/vdic_mult_pipe.sv
// Pipelined signed multiplier with operand parity checking, an operand queue and
// a valid/ack result handshake. Define VDIC_MULT_ERR_CNT_EN to add the err_cnt port.
module vdic_mult_pipe #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MUL_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_W-1:0]                arg_a,
  input  logic                             arg_a_parity,
  input  logic [DATA_W-1:0]                arg_b,
  input  logic                             arg_b_parity,
  input  logic                             req,
  output logic                             ack,
  output logic [2*DATA_W-1:0]              result,
  output logic                             result_parity,
  output logic                             arg_parity_error,
  output logic                             result_rdy,
  input  logic                             result_ack,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
`ifdef VDIC_MULT_ERR_CNT_EN
  ,
  output logic [15:0]                      err_cnt
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RW = 2 * DATA_W;
  localparam int EW = 2 * DATA_W + 2;
  localparam int LS = MUL_STAGES - 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  // Operand queue
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [LW-1:0]     w_level_next;
  logic              r_ack;

  logic              w_push;
  logic              w_pop;
  logic              w_adv;
  logic              w_empty;

  // Queue head and issue-stage computation
  logic [DATA_W-1:0] w_head_a;
  logic [DATA_W-1:0] w_head_b;
  logic              w_head_ap;
  logic              w_head_bp;
  logic              w_err;
  logic signed [RW-1:0] w_prod_full;
  logic              w_s1_vld;
  logic              w_s1_err;
  logic [RW-1:0]     w_s1_prod;
  logic [RW-1:0]     w_last_in;

  // Pipeline stages; index LS is the output register
  logic [MUL_STAGES-1:0] r_vld;
  logic [MUL_STAGES-1:0] r_err;
  logic [RW-1:0]         r_prod [MUL_STAGES];
  logic                  r_par;

  // Global stall: nothing moves while an unconsumed result is presented.
  assign w_adv   = !r_vld[LS] || result_ack;
  assign w_empty = (r_level == '0);
  assign w_push  = req && r_ack;
  assign w_pop   = w_adv && !w_empty;

  assign {w_head_a, w_head_ap, w_head_b, w_head_bp} = r_mem[r_rd_ptr];

  assign w_err       = ((^w_head_a) != w_head_ap) || ((^w_head_b) != w_head_bp);
  assign w_prod_full = $signed(w_head_a) * $signed(w_head_b);

  assign w_s1_vld  = w_pop;
  assign w_s1_err  = w_pop && w_err;
  assign w_s1_prod = (w_pop && !w_err) ? w_prod_full : '0;

  // Parity is computed on the value entering the output register.
  if (MUL_STAGES == 1) begin : g_last_direct
    assign w_last_in = w_s1_prod;
  end else begin : g_last_shift
    assign w_last_in = r_prod[MUL_STAGES-2];
  end

  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop)
      w_level_next = r_level + LW'(1);
    else if (w_pop && !w_push)
      w_level_next = r_level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {arg_a, arg_a_parity, arg_b, arg_b_parity};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ack    <= 1'b0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= w_level_next;
      r_ack   <= (w_level_next < DEPTH_L);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_err <= '0;
      r_par <= 1'b0;
      for (int unsigned i = 0; i < MUL_STAGES; i++)
        r_prod[i] <= '0;
    end else if (w_adv) begin
      r_vld[0]  <= w_s1_vld;
      r_err[0]  <= w_s1_err;
      r_prod[0] <= w_s1_prod;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_err[i]  <= r_err[i-1];
        r_prod[i] <= r_prod[i-1];
      end
      r_par <= ^w_last_in;
    end
  end

`ifdef VDIC_MULT_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_err_cnt <= '0;
    else if (r_vld[LS] && result_ack && r_err[LS] && (r_err_cnt != '1))
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

  assign ack              = r_ack;
  assign fifo_level       = r_level;
  assign result           = r_prod[LS];
  assign result_parity    = r_par;
  assign arg_parity_error = r_err[LS];
  assign result_rdy       = r_vld[LS];

endmodule
